// File: rtl/neuron_fixed_pkg.sv
// Shared constants and FSM state type for the Q3.12 perceptron trainer.
// Saturation limits are used when TRAIN_SAT_EN is defined.
package neuron_fixed_pkg;
    localparam int          FRAC_BITS = 12;
    localparam logic [15:0] Q_ONE     = 16'h1000;
    localparam logic [15:0] SAT_MAX   = 16'h7FFF;
    localparam logic [15:0] SAT_MIN   = 16'h8000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/fixed_mul_q.sv
// Signed Q3.12 multiplier: full-width product, arithmetic shift right by
// FRAC_BITS, then clamp (TRAIN_SAT_EN defined) or truncate (default).
module fixed_mul_q
    import neuron_fixed_pkg::*;
#(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] p_o
);
    logic signed [2*W-1:0] prod;

    assign prod = a_i * b_i;

`ifdef TRAIN_SAT_EN
    localparam logic signed [2*W-1:0] PMAX = {{W{1'b0}}, W'(SAT_MAX)};
    localparam logic signed [2*W-1:0] PMIN = {{W{1'b1}}, W'(SAT_MIN)};

    logic signed [2*W-1:0] shf;

    // Rescale and clamp to the representable Q3.12 range.
    always_comb begin
        shf = prod >>> FRAC_BITS;
        if (shf > PMAX)
            p_o = W'(SAT_MAX);
        else if (shf < PMIN)
            p_o = W'(SAT_MIN);
        else
            p_o = W'(shf);
    end
`else
    // Rescale and keep the low W bits (two's-complement wrap).
    assign p_o = W'(prod >>> FRAC_BITS);
`endif
endmodule

// File: rtl/perceptron_trainer_fixed.sv
// Perceptron trainer over four Q3.12 samples. Each sample takes an EVAL
// cycle (compute s, register the error sign) and an UPDATE cycle (apply
// the correction). Two multipliers are shared: in EVAL they form w*x,
// in UPDATE they form LR*x. Macro TRAIN_SAT_EN selects saturating
// arithmetic; otherwise results wrap.
module perceptron_trainer_fixed
    import neuron_fixed_pkg::*;
#(
    parameter int             tam        = 16,
    parameter logic [tam-1:0] LR         = 16'h0400,
    parameter int             MAX_EPOCHS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0][tam-1:0]  in1,
    input  logic [3:0][tam-1:0]  in2,
    input  logic [3:0][tam-1:0]  d,
    input  logic [tam-1:0]       w0_init,
    input  logic [tam-1:0]       w1_init,
    input  logic [tam-1:0]       w2_init,
    output logic [tam-1:0]       w0,
    output logic [tam-1:0]       w1,
    output logic [tam-1:0]       w2,
    output logic                 busy,
    output logic                 done,
    output logic                 converged,
    output logic [7:0]           epoch_cnt
);
    // Two guard bits so a three-term sum never overflows before fitting.
    localparam int XW = tam + 2;

    function automatic logic signed [XW-1:0] ext(input logic [tam-1:0] v);
        ext = {{2{v[tam-1]}}, v};
    endfunction

    function automatic logic [tam-1:0] fit(input logic signed [XW-1:0] x);
`ifdef TRAIN_SAT_EN
        if (x > $signed({2'b00, tam'(SAT_MAX)}))
            fit = tam'(SAT_MAX);
        else if (x < $signed({2'b11, tam'(SAT_MIN)}))
            fit = tam'(SAT_MIN);
        else
            fit = tam'(x);
`else
        fit = tam'(x);
`endif
    endfunction

    state_t         state_q, state_d;
    logic [tam-1:0] w0_q, w1_q, w2_q;
    logic [1:0]     idx_q;
    logic [2:0]     errs_q;
    logic           err_q;    // current sample misclassified
    logic           pos_q;    // error sign: 1 -> e=+1, 0 -> e=-1
    logic           conv_q;
    logic [7:0]     epoch_q;

    logic [tam-1:0] x1, x2, ma1, ma2, p1, p2, s;
    logic [tam-1:0] w0_n, w1_n, w2_n;
    logic           tgt, y, last, clean, limit;

    assign x1  = in1[idx_q];
    assign x2  = in2[idx_q];
    assign tgt = (d[idx_q] != '0);

    assign ma1 = (state_q == UPDATE) ? LR : w1_q;
    assign ma2 = (state_q == UPDATE) ? LR : w2_q;

    fixed_mul_q #(.W(tam)) u_mul1 (.a_i(ma1), .b_i(x1), .p_o(p1));
    fixed_mul_q #(.W(tam)) u_mul2 (.a_i(ma2), .b_i(x2), .p_o(p2));

    assign s = fit(ext(w0_q) + ext(p1) + ext(p2));
    assign y = !s[tam-1] && (s != '0);

    // e is +1 when target is 1, -1 when target is 0 (only applied if err_q).
    assign w0_n = pos_q ? fit(ext(w0_q) + ext(LR)) : fit(ext(w0_q) - ext(LR));
    assign w1_n = pos_q ? fit(ext(w1_q) + ext(p1)) : fit(ext(w1_q) - ext(p1));
    assign w2_n = pos_q ? fit(ext(w2_q) + ext(p2)) : fit(ext(w2_q) - ext(p2));

    assign last  = (idx_q == 2'd3);
    assign clean = (errs_q == 3'd0) && !err_q;
    assign limit = ((epoch_q + 8'd1) == 8'(MAX_EPOCHS));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = EVAL;
            EVAL:       state_d = UPDATE;
            UPDATE: begin
                if (!last)                state_d = EVAL;
                else if (clean || limit)  state_d = DONE;
                else                      state_d = EVAL;
            end
            default:    state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state_q == EVAL) || (state_q == UPDATE);
        done = (state_q == DONE);
    end

    // Weights, sample index, error bookkeeping and epoch counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            w0_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            idx_q   <= '0;
            errs_q  <= '0;
            err_q   <= 1'b0;
            pos_q   <= 1'b0;
            conv_q  <= 1'b0;
            epoch_q <= '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        w0_q    <= w0_init;
                        w1_q    <= w1_init;
                        w2_q    <= w2_init;
                        idx_q   <= '0;
                        errs_q  <= '0;
                        err_q   <= 1'b0;
                        conv_q  <= 1'b0;
                        epoch_q <= '0;
                    end
                end
                EVAL: begin
                    err_q <= (tgt != y);
                    pos_q <= tgt;
                end
                UPDATE: begin
                    if (err_q) begin
                        w0_q <= w0_n;
                        w1_q <= w1_n;
                        w2_q <= w2_n;
                    end
                    if (last) begin
                        epoch_q <= epoch_q + 8'd1;
                        idx_q   <= '0;
                        errs_q  <= '0;
                        if (clean) conv_q <= 1'b1;
                    end else begin
                        idx_q  <= idx_q + 2'd1;
                        errs_q <= errs_q + {2'b00, err_q};
                    end
                end
                default: ;
            endcase
        end
    end

    assign w0        = w0_q;
    assign w1        = w1_q;
    assign w2        = w2_q;
    assign converged = conv_q;
    assign epoch_cnt = epoch_q;
endmodule

// File: tb/tb_perceptron_trainer_fixed.sv
// Scoreboard bench for perceptron_trainer_fixed. Expected results come from
// an integer reference of the training rule; a monitor compares on each
// rising edge of done. Honours TRAIN_SAT_EN like the design.
module tb_perceptron_trainer_fixed;
    import neuron_fixed_pkg::*;

    localparam int MAXE = 32;
    localparam int LRV  = 'h0400;

    logic              clk = 1'b0;
    logic              rst, start;
    logic [3:0][15:0]  in1, in2, d;
    logic [15:0]       w0_init, w1_init, w2_init;
    logic [15:0]       w0, w1, w2;
    logic              busy, done, converged;
    logic [7:0]        epoch_cnt;

    perceptron_trainer_fixed dut (
        .clk(clk), .rst(rst), .start(start),
        .in1(in1), .in2(in2), .d(d),
        .w0_init(w0_init), .w1_init(w1_init), .w2_init(w2_init),
        .w0(w0), .w1(w1), .w2(w2),
        .busy(busy), .done(done), .converged(converged), .epoch_cnt(epoch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w0, w1, w2;
        logic        conv;
        int          ep;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0, checks = 0;
    int   cyc = 0, start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic int fitm(input longint x);
`ifdef TRAIN_SAT_EN
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return int'(x);
`else
        logic signed [15:0] t;
        t = x[15:0];
        return int'(t);
`endif
    endfunction

    function automatic int mulm(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return fitm(p >>> 12);
    endfunction

    // Reference: plain perceptron rule over the current tb inputs.
    function automatic exp_t model();
        exp_t e;
        int a, b, c, s, y, t, ev, errs, x1, x2;
        a = int'($signed(w0_init));
        b = int'($signed(w1_init));
        c = int'($signed(w2_init));
        e.conv = 1'b0;
        e.ep   = 0;
        for (int ep = 1; ep <= MAXE; ep++) begin
            errs = 0;
            for (int i = 0; i < 4; i++) begin
                x1 = int'($signed(in1[i]));
                x2 = int'($signed(in2[i]));
                s  = fitm(longint'(a) + mulm(b, x1) + mulm(c, x2));
                y  = (s > 0) ? 1 : 0;
                t  = (d[i] != 16'h0) ? 1 : 0;
                ev = t - y;
                if (ev != 0) begin
                    errs++;
                    a = fitm(longint'(a) + ev * LRV);
                    b = fitm(longint'(b) + ev * mulm(LRV, x1));
                    c = fitm(longint'(c) + ev * mulm(LRV, x2));
                end
            end
            e.ep = ep;
            if (errs == 0) begin
                e.conv = 1'b1;
                break;
            end
        end
        e.w0  = a[15:0];
        e.w1  = b[15:0];
        e.w2  = c[15:0];
        e.cyc = 8 * e.ep;
        return e;
    endfunction

    // Monitor: compare each completed training run against the scoreboard.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending run");
                end else begin
                    e = sb.pop_front();
                    chk("w0", w0, e.w0);
                    chk("w1", w1, e.w1);
                    chk("w2", w2, e.w2);
                    chk("converged", converged, e.conv);
                    chk("epoch_cnt", epoch_cnt, e.ep);
                    chk("latency", cyc - start_cyc, e.cyc);
                end
            end
            prev = done;
        end
    end

    task automatic issue(input bit push, input bit use_fx, input exp_t fx);
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc + 1;
        if (push) sb.push_back(use_fx ? fx : model());
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 700 && sb.size() != 0; k++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout: got no done after 700 cycles expected done");
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_w0"}, w0, 0);
        chk({tag, "_w1"}, w1, 0);
        chk({tag, "_w2"}, w2, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_conv"}, converged, 0);
        chk({tag, "_epoch"}, epoch_cnt, 0);
    endtask

    task automatic set_and();
        in1[0] = 16'h0; in1[1] = Q_ONE; in1[2] = 16'h0; in1[3] = Q_ONE;
        in2[0] = 16'h0; in2[1] = 16'h0; in2[2] = Q_ONE; in2[3] = Q_ONE;
        d[0]   = 16'h0; d[1]   = 16'h0; d[2]   = 16'h0; d[3]   = Q_ONE;
    endtask

    task automatic set_w(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        w0_init = a; w1_init = b; w2_init = c;
    endtask

    function automatic logic [15:0] rnd_q();
        int tmp;
        if ($urandom_range(0, 3) == 0) tmp = int'($urandom_range(0, 65535));
        else                           tmp = int'($urandom_range(0, 16384)) - 8192;
        return tmp[15:0];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t fx, and_fx, dummy;
        and_fx = '{w0: 16'hF800, w1: 16'h0400, w2: 16'h0800, conv: 1'b1, ep: 6, cyc: 48};
        dummy  = and_fx;
        rst = 1'b1; start = 1'b0;
        in1 = '0; in2 = '0; d = '0;
        set_w(16'h0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // AND gate from zero weights.
        set_and();
        issue(1, 1, and_fx);
        drain();

        // XOR never separates: hits the epoch limit.
        d[0] = 16'h0; d[1] = Q_ONE; d[2] = Q_ONE; d[3] = 16'h0;
        fx = model();
        fx.conv = 1'b0; fx.ep = 32; fx.cyc = 256;
        issue(1, 1, fx);
        drain();

        // Already-trained weights: one clean epoch.
        set_and();
        set_w(16'hF800, 16'h0400, 16'h0800);
        fx = '{w0: 16'hF800, w1: 16'h0400, w2: 16'h0800, conv: 1'b1, ep: 1, cyc: 8};
        issue(1, 1, fx);
        drain();

        // Start pulsed while busy is ignored.
        set_w(16'h0, 16'h0, 16'h0);
        issue(1, 1, and_fx);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset mid-epoch, then a clean rerun.
        issue(0, 1, dummy);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midrst");
        issue(1, 1, and_fx);
        drain();

        // Weight update that overflows: wraps by default, clamps with saturation.
        for (int i = 0; i < 4; i++) begin
            in1[i] = 16'h7FFF; in2[i] = 16'h0; d[i] = Q_ONE;
        end
        set_w(16'h8000, 16'h7000, 16'h0);
        issue(1, 0, dummy);
        drain();

        // Randomized runs against the reference.
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 4; i++) begin
                in1[i] = rnd_q();
                in2[i] = rnd_q();
                d[i]   = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(1, 65535)) : 16'h0;
            end
            set_w(rnd_q(), rnd_q(), rnd_q());
            issue(1, 0, dummy);
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
